odo_sbox_serial_layer: RTL

- Serialised S-box substitution layer for the Odo hash datapath.
- Accepts a wide state word over a valid/ready handshake and splits it into 6-bit chunks.
- Drives each chunk into one external odo_sbox_small* instance, one chunk per cycle, and reassembles the substituted chunks into an output word, also delivered over valid/ready.
- Sits directly upstream of, and consumes the output of, the registered 1-cycle-latency 6-bit S-box.

---
 rtl/odo_sbox_serial_layer_if.sv | 26 ++
 rtl/odo_sbox_serial_layer.sv | 105 ++++++++++
 2 files changed

// File: rtl/odo_sbox_serial_layer_if.sv
// Handshake and S-box bus bundle for the serial S-box layer.
// The master side feeds words and hosts the external S-box; the slave is the layer.
interface odo_sbox_serial_layer_if #(
    parameter int N_CHUNKS = 4
) ();
    localparam int W = 6 * N_CHUNKS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [5:0]   sbox_in;
    logic [5:0]   sbox_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, sbox_out, out_ready,
        input  in_ready, sbox_in, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, sbox_out, out_ready,
        output in_ready, sbox_in, out_valid, out_data
    );
endinterface

// File: rtl/odo_sbox_serial_layer.sv
// Serialised 6-bit S-box layer: streams chunks of a latched word through a
// registered 1-cycle external S-box and reassembles the substituted word.
module odo_sbox_serial_layer #(
    parameter int N_CHUNKS = 4,
    parameter int IDX_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    odo_sbox_serial_layer_if.slave bus,
    output logic                  busy
);
    localparam int W     = 6 * N_CHUNKS;
    localparam int SEL_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(N_CHUNKS - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic [N_CHUNKS-1:0][5:0]   word_q;
    logic [N_CHUNKS-1:0][5:0]   res_q;
    logic [N_CHUNKS-1:0][5:0]   res_d;
    logic [W-1:0]               out_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic                       busy_q;
    logic [SEL_W-1:0]           sel_cur;
    logic [SEL_W-1:0]           sel_prev;

    assign sel_cur  = idx_q[SEL_W-1:0];
    assign sel_prev = sel_cur - SEL_W'(1);

    assign bus.sbox_in   = (state_q == RUN) ? word_q[sel_cur] : 6'd0;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
    assign busy          = busy_q;

    // Merge the S-box result (one cycle behind sbox_in) into the result word
    always_comb begin
        res_d = res_q;
        if (state_q == RUN && idx_q != '0) begin
            res_d[sel_prev] = bus.sbox_out;
        end else if (state_q == DRAIN) begin
            res_d[LAST_SEL] = bus.sbox_out;
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            word_q      <= '0;
            res_q       <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_q <= res_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        word_q     <= bus.in_data;
                        idx_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx_q == LAST) begin
                        state_q <= DRAIN;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    state_q     <= DONE;
                    out_q       <= res_d;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
